// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-schedule types, mode helpers and GF(2^8) xtime
package aes_pkg;

    typedef enum logic [1:0] {
        AES_128 = 2'b00,
        AES_192 = 2'b01,
        AES_256 = 2'b10,
        AES_BAD = 2'b11
    } aes_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXPAND,
        ST_ZERO
    } ks_state_e;

    localparam int AES_MAX_WORDS = 60;

    function automatic logic [3:0] nk_of(input aes_mode_e m);
        case (m)
            AES_192: return 4'd6;
            AES_256: return 4'd8;
            default: return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input aes_mode_e m);
        case (m)
            AES_192: return 4'd12;
            AES_256: return 4'd14;
            default: return 4'd10;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_subword.sv
// rtl/aes_subword.sv - AES SubWord: four parallel forward S-box lookups, combinational
module aes_subword (
    input  logic [31:0] din,
    output logic [31:0] dout
);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte, so byte b lives at bit offset (255-b)*8 = {~b,3'b0}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign dout[8*g +: 8] = sbox(din[8*g +: 8]);
    end

endmodule

// File: rtl/aes_keysched_seq.sv
// rtl/aes_keysched_seq.sv - word-serial AES-128/192/256 key expansion into slots; option AES_KEYSCHED_ZEROIZE_EN
module aes_keysched_seq
    import aes_pkg::*;
#(
    parameter  int KEY_SLOTS  = 2,
    parameter  int MAX_ROUNDS = 14,
    localparam int SW         = (KEY_SLOTS > 1) ? $clog2(KEY_SLOTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 ready,
    input  logic [1:0]           mode,
    input  logic [255:0]         key_in,
    input  logic [SW-1:0]        wr_slot,
    output logic                 done,
    output logic                 err,
    output logic [KEY_SLOTS-1:0] slot_valid,
    input  logic [SW-1:0]        rd_slot,
    input  logic [3:0]           rd_round,
`ifdef AES_KEYSCHED_ZEROIZE_EN
    input  logic                 zeroize,
`endif
    output logic [127:0]         rd_key
);

    localparam int WORDS_MAX = 4 * (MAX_ROUNDS + 1);

    ks_state_e     state, state_nx;
    aes_mode_e     cur_mode;
    logic [SW-1:0] cur_slot;
    logic [5:0]    widx;
    logic [2:0]    imod;
    logic [7:0]    rcon;
    logic [31:0]   win [8];
    logic [31:0]   mem [KEY_SLOTS][WORDS_MAX];
    aes_mode_e     slot_mode [KEY_SLOTS];

    logic          slot_ok, mode_ok, accept, bad_start, last_word, zero_go, rd_ok;
    logic [3:0]    nk, nk_in;
    logic [255:0]  key_al;
    logic [31:0]   t_prev, sub_in, sub_out, t_mix, w_new;
    logic [5:0]    rd_base;

`ifdef AES_KEYSCHED_ZEROIZE_EN
    logic [SW-1:0] zslot;
    assign zero_go = zeroize && (state != ST_ZERO);
`else
    assign zero_go = 1'b0;
`endif

    assign ready     = (state == ST_IDLE);
    assign nk        = nk_of(cur_mode);
    assign nk_in     = nk_of(aes_mode_e'(mode));
    assign slot_ok   = int'(wr_slot) < KEY_SLOTS;
    assign mode_ok   = (mode != AES_BAD) && (int'(nr_of(aes_mode_e'(mode))) <= MAX_ROUNDS);
    assign accept    = start && ready && slot_ok && mode_ok && !zero_go;
    assign bad_start = start && ready && !(slot_ok && mode_ok) && !zero_go;
    assign last_word = (widx == {nr_of(cur_mode), 2'b11});

    // win[7] holds w[i-1]; w[i-Nk] is therefore at win[8-Nk].
    assign key_al  = key_in >> (9'd32 * 9'(4'd8 - nk_in));
    assign t_prev  = win[7];
    assign sub_in  = (imod == 3'd0) ? {t_prev[23:0], t_prev[31:24]} : t_prev;

    aes_subword u_subword (
        .din  (sub_in),
        .dout (sub_out)
    );

    always_comb begin
        t_mix = t_prev;
        if (imod == 3'd0)
            t_mix = sub_out ^ {rcon, 24'h0};
        else if (nk == 4'd8 && imod == 3'd4)
            t_mix = sub_out;
    end

    assign w_new   = win[3'(4'd8 - nk)] ^ t_mix;
    assign rd_base = {rd_round, 2'b00};
    assign rd_ok   = (int'(rd_slot) < KEY_SLOTS) && slot_valid[rd_slot] &&
                     (rd_round <= nr_of(slot_mode[rd_slot])) && !zero_go;

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (accept) state_nx = ST_EXPAND;
            ST_EXPAND: if (last_word) state_nx = ST_IDLE;
`ifdef AES_KEYSCHED_ZEROIZE_EN
            ST_ZERO:   if (zslot == SW'(KEY_SLOTS - 1)) state_nx = ST_IDLE;
`endif
            default:   state_nx = ST_IDLE;
        endcase
        if (zero_go) state_nx = ST_ZERO;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done       <= 1'b0;
            err        <= 1'b0;
            slot_valid <= '0;
            rd_key     <= '0;
            cur_mode   <= AES_128;
            cur_slot   <= '0;
            widx       <= '0;
            imod       <= '0;
            rcon       <= 8'h01;
`ifdef AES_KEYSCHED_ZEROIZE_EN
            zslot      <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= bad_start;
            if (accept) begin
                cur_mode            <= aes_mode_e'(mode);
                cur_slot            <= wr_slot;
                widx                <= 6'(nk_in);
                imod                <= 3'd0;
                rcon                <= 8'h01;
                slot_valid[wr_slot] <= 1'b0;
            end else if (state == ST_EXPAND) begin
                widx <= widx + 6'd1;
                imod <= (imod == 3'(nk - 4'd1)) ? 3'd0 : imod + 3'd1;
                if (imod == 3'd0) rcon <= xtime(rcon);
                if (last_word) begin
                    done                 <= 1'b1;
                    slot_valid[cur_slot] <= 1'b1;
                end
            end
`ifdef AES_KEYSCHED_ZEROIZE_EN
            if (zero_go) begin
                done       <= 1'b0;
                slot_valid <= '0;
                zslot      <= '0;
            end else if (state == ST_ZERO) begin
                zslot <= zslot + SW'(1);
            end
`endif
            if (rd_ok)
                rd_key <= {mem[rd_slot][rd_base], mem[rd_slot][{rd_round, 2'b01}],
                           mem[rd_slot][{rd_round, 2'b10}], mem[rd_slot][{rd_round, 2'b11}]};
            else
                rd_key <= '0;
        end
    end

    // Key storage and the sliding window are deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            slot_mode[wr_slot] <= aes_mode_e'(mode);
            for (int j = 0; j < 8; j++) begin
                win[j] <= key_al[32*(7-j) +: 32];
                if (j < int'(nk_in)) mem[wr_slot][j] <= key_in[255-32*j -: 32];
            end
        end else if (state == ST_EXPAND) begin
            mem[cur_slot][widx] <= w_new;
            for (int j = 0; j < 7; j++) win[j] <= win[j+1];
            win[7] <= w_new;
        end
`ifdef AES_KEYSCHED_ZEROIZE_EN
        else if (state == ST_ZERO) begin
            for (int j = 0; j < WORDS_MAX; j++) mem[zslot][j] <= '0;
        end
`endif
    end

endmodule

// File: tb/tb_aes_keysched_seq.sv
// tb/tb_aes_keysched_seq.sv - directed self-checking bench for aes_keysched_seq
module tb_aes_keysched_seq;

    localparam logic [255:0] K128   = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192   = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R128_0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R128_1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R128_9 = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] R128_A = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R192_1 = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
    localparam logic [127:0] R192_C = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R256_1 = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R256_2 = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] R256_E = 128'hfe4890d1e6188d0b046df344706c631e;

    logic         clk = 1'b0;
    logic         rst_n, start, ready, done, err;
    logic [1:0]   mode;
    logic [255:0] key_in;
    logic [0:0]   wr_slot, rd_slot;
    logic [1:0]   slot_valid;
    logic [3:0]   rd_round;
    logic [127:0] rd_key;
`ifdef AES_KEYSCHED_ZEROIZE_EN
    logic         zeroize = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    aes_keysched_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ready      (ready),
        .mode       (mode),
        .key_in     (key_in),
        .wr_slot    (wr_slot),
        .done       (done),
        .err        (err),
        .slot_valid (slot_valid),
        .rd_slot    (rd_slot),
        .rd_round   (rd_round),
`ifdef AES_KEYSCHED_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .rd_key     (rd_key)
    );

    task automatic read_key(input logic s, input logic [3:0] r, output logic [127:0] q);
        rd_slot = s; rd_round = r;
        @(negedge clk);
        q = rd_key;
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_expand(input logic [1:0] m, input logic [255:0] k, input logic s,
                              input int exp_edges, input string name);
        int edges;
        start = 1'b1; mode = m; key_in = k; wr_slot = s;
        @(negedge clk); start = 1'b0; edges = 1;
        n_vec++; if (ready !== 1'b0) begin n_err++; $display("FAIL %s busy_ready got %b want 0", name, ready); end
        while (done !== 1'b1 && edges < 100) begin @(negedge clk); edges++; end
        n_vec++; if (edges !== exp_edges) begin n_err++; $display("FAIL %s latency got %0d want %0d", name, edges, exp_edges); end
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL %s done_ready got %b want 1", name, ready); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; mode = 2'b00; key_in = '0; wr_slot = 1'b0; rd_slot = 1'b0; rd_round = 4'd0;
        repeat (2) @(negedge clk);
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", ready); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", err); end
        n_vec++; if (slot_valid !== 2'b00) begin n_err++; $display("FAIL reset_valid got %b want 00", slot_valid); end
        n_vec++; if (rd_key !== 128'h0) begin n_err++; $display("FAIL reset_rdkey got %h want 0", rd_key); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aes128();
        logic [127:0] q;
        run_expand(2'b00, K128, 1'b0, 41, "aes128");
        n_vec++; if (slot_valid !== 2'b01) begin n_err++; $display("FAIL a128_valid got %b want 01", slot_valid); end
        read_key(1'b0, 4'd0, q);
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL a128_done_pulse got %b want 0", done); end
        n_vec++; if (q !== R128_0) begin n_err++; $display("FAIL a128_r0 got %h want %h", q, R128_0); end
        read_key(1'b0, 4'd1, q);
        n_vec++; if (q !== R128_1) begin n_err++; $display("FAIL a128_r1 got %h want %h", q, R128_1); end
        read_key(1'b0, 4'd9, q);
        n_vec++; if (q !== R128_9) begin n_err++; $display("FAIL a128_r9 got %h want %h", q, R128_9); end
        read_key(1'b0, 4'd10, q);
        n_vec++; if (q !== R128_A) begin n_err++; $display("FAIL a128_r10 got %h want %h", q, R128_A); end
        read_key(1'b0, 4'd11, q);
        n_vec++; if (q !== 128'h0) begin n_err++; $display("FAIL a128_r11 got %h want 0", q); end
    endtask

    task automatic test_concurrent_read();
        logic [127:0] q, want;
        logic last;
        int edges;
        start = 1'b1; mode = 2'b01; key_in = K192; wr_slot = 1'b1; rd_slot = 1'b0; rd_round = 4'd10;
        @(negedge clk); start = 1'b0; edges = 1; last = 1'b0;
        while (done !== 1'b1 && edges < 100) begin
            want = (last == 1'b0) ? R128_A : 128'h0;
            n_vec++; if (rd_key !== want) begin n_err++; $display("FAIL conc_rd slot %0d edge %0d got %h want %h", last, edges, rd_key, want); end
            last = ~last; rd_slot = last;
            @(negedge clk); edges++;
        end
        want = (last == 1'b0) ? R128_A : 128'h0;
        n_vec++; if (rd_key !== want) begin n_err++; $display("FAIL conc_rd_final got %h want %h", rd_key, want); end
        n_vec++; if (edges !== 47) begin n_err++; $display("FAIL a192_latency got %0d want 47", edges); end
        n_vec++; if (slot_valid !== 2'b11) begin n_err++; $display("FAIL a192_valid got %b want 11", slot_valid); end
        read_key(1'b1, 4'd1, q);
        n_vec++; if (q !== R192_1) begin n_err++; $display("FAIL a192_r1 got %h want %h", q, R192_1); end
        read_key(1'b1, 4'd12, q);
        n_vec++; if (q !== R192_C) begin n_err++; $display("FAIL a192_r12 got %h want %h", q, R192_C); end
        read_key(1'b1, 4'd13, q);
        n_vec++; if (q !== 128'h0) begin n_err++; $display("FAIL a192_r13 got %h want 0", q); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] q;
        run_expand(2'b00, K128, 1'b0, 41, "b2b_128");
        run_expand(2'b10, K256, 1'b1, 53, "b2b_256");
        read_key(1'b1, 4'd1, q);
        n_vec++; if (q !== R256_1) begin n_err++; $display("FAIL a256_r1 got %h want %h", q, R256_1); end
        read_key(1'b1, 4'd2, q);
        n_vec++; if (q !== R256_2) begin n_err++; $display("FAIL a256_r2 got %h want %h", q, R256_2); end
        read_key(1'b1, 4'd14, q);
        n_vec++; if (q !== R256_E) begin n_err++; $display("FAIL a256_r14 got %h want %h", q, R256_E); end
        read_key(1'b1, 4'd15, q);
        n_vec++; if (q !== 128'h0) begin n_err++; $display("FAIL a256_r15 got %h want 0", q); end
        read_key(1'b0, 4'd10, q);
        n_vec++; if (q !== R128_A) begin n_err++; $display("FAIL b2b_slot0_r10 got %h want %h", q, R128_A); end
    endtask

    task automatic test_illegal();
        start = 1'b1; mode = 2'b11; wr_slot = 1'b0;
        @(negedge clk); start = 1'b0;
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL illegal_err got %b want 1", err); end
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL illegal_ready got %b want 1", ready); end
        n_vec++; if (slot_valid !== 2'b11) begin n_err++; $display("FAIL illegal_valid got %b want 11", slot_valid); end
        @(negedge clk);
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL illegal_err_pulse got %b want 0", err); end
    endtask

    task automatic test_busy();
        logic [127:0] q;
        int edges;
        start = 1'b1; mode = 2'b00; key_in = K128; wr_slot = 1'b1;
        @(negedge clk); start = 1'b0; edges = 1;
        repeat (5) begin @(negedge clk); edges++; end
        start = 1'b1; mode = 2'b11; wr_slot = 1'b0;
        @(negedge clk); start = 1'b0; edges++;
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL busy_err got %b want 0", err); end
        while (done !== 1'b1 && edges < 100) begin @(negedge clk); edges++; end
        n_vec++; if (edges !== 41) begin n_err++; $display("FAIL busy_latency got %0d want 41", edges); end
        read_key(1'b1, 4'd10, q);
        n_vec++; if (q !== R128_A) begin n_err++; $display("FAIL busy_slot1_r10 got %h want %h", q, R128_A); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] q;
        logic seen;
        start = 1'b1; mode = 2'b10; key_in = K256; wr_slot = 1'b0;
        @(negedge clk); start = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++; if (slot_valid !== 2'b00) begin n_err++; $display("FAIL rstmid_valid got %b want 00", slot_valid); end
        n_vec++; if (ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b want 1", ready); end
        @(negedge clk); rst_n = 1'b1; seen = 1'b0;
        repeat (60) begin @(negedge clk); if (done === 1'b1) seen = 1'b1; end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_done got %b want 0", seen); end
        read_key(1'b1, 4'd0, q);
        n_vec++; if (q !== 128'h0) begin n_err++; $display("FAIL rstmid_read got %h want 0", q); end
    endtask

`ifdef AES_KEYSCHED_ZEROIZE_EN
    task automatic test_zeroize();
        logic [127:0] q;
        int low;
        logic seen;
        run_expand(2'b00, K128, 1'b0, 41, "zero_pre");
        start = 1'b1; mode = 2'b01; key_in = K192; wr_slot = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        zeroize = 1'b1;
        @(negedge clk); zeroize = 1'b0; low = 0; seen = 1'b0;
        repeat (60) begin
            if (ready === 1'b0) low++;
            if (done === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        n_vec++; if (low !== 2) begin n_err++; $display("FAIL zero_ready_low got %0d want 2", low); end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL zero_done got %b want 0", seen); end
        n_vec++; if (slot_valid !== 2'b00) begin n_err++; $display("FAIL zero_valid got %b want 00", slot_valid); end
        read_key(1'b0, 4'd0, q);
        n_vec++; if (q !== 128'h0) begin n_err++; $display("FAIL zero_read got %h want 0", q); end
    endtask
`endif

    initial begin
        test_reset();
        test_aes128();
        test_concurrent_read();
        test_back_to_back();
        test_illegal();
        test_busy();
        test_reset_mid();
`ifdef AES_KEYSCHED_ZEROIZE_EN
        test_zeroize();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
